// File: rtl/sum_result_bcd_pkg.sv
// Shared types and constants for the summation result BCD converter.
// Segment constants are consumed only when SUM_BCD_SEG_EN is defined.
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ERR = 4'hF;

  // Active-low 7-segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sum_result_bcd_if.sv
// Bus between the summation datapath, the BCD converter and its consumer.
// The seg field exists only when SUM_BCD_SEG_EN is defined.
interface sum_result_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  ready;
  logic [WIDTH-1:0]      total;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic                  busy;
  logic                  err;
`ifdef SUM_BCD_SEG_EN
  logic [7*DIGITS-1:0]   seg;

  modport master (output ready, total, overflow,
                  input  bcd, bcd_valid, busy, err, seg);
  modport slave  (input  ready, total, overflow,
                  output bcd, bcd_valid, busy, err, seg);
`else
  modport master (output ready, total, overflow,
                  input  bcd, bcd_valid, busy, err);
  modport slave  (input  ready, total, overflow,
                  output bcd, bcd_valid, busy, err);
`endif
endinterface

// File: rtl/sum_result_bcd_seg.sv
// 4-bit BCD digit to active-low 7-segment (gfedcba) decoder.
// Instantiated by the top only when SUM_BCD_SEG_EN is defined.
module bcd_seg_decode
  import sum_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      BCD_ERR: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/sum_result_bcd.sv
// Captures total/overflow on the rising edge of ready and converts it to BCD
// with a sequential double-dabble engine. SUM_BCD_SEG_EN adds a registered seg output.
module sum_result_bcd
  import sum_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
)(
  input  logic             clk,
  input  logic             rst,
  sum_result_bcd_if.slave  bus
);
  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]              state;
  logic                    ready_q;
  logic [SW-1:0]           scratch;
  logic                    ovf_cap;
  logic [CW-1:0]           cnt;
  logic [4*DIGITS-1:0]     bcd_r;
  logic                    valid_r;
  logic                    busy_r;
  logic                    err_r;

  logic                    start;
  logic [DIGITS-1:0][3:0]  dig;
  logic [DIGITS-1:0][3:0]  dig_adj;
  logic [SW-1:0]           adj_scr;
  logic [4*DIGITS-1:0]     bcd_nxt;

  assign start = bus.ready & ~ready_q;

  // Add-3 correction on every digit before each shift
  assign dig = scratch[SW-1:WIDTH];
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign dig_adj[g] = (dig[g] >= 4'd5) ? dig[g] + 4'd3 : dig[g];
  end
  assign adj_scr = {dig_adj, scratch[WIDTH-1:0]};

  // An overflowed result is reported as an all-F error code
  assign bcd_nxt = ovf_cap ? {DIGITS{BCD_ERR}} : scratch[SW-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
      scratch <= '0;
      ovf_cap <= 1'b0;
      cnt     <= '0;
      bcd_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_q <= bus.ready;
      case (state)
        S_IDLE: begin
          if (start) begin
            scratch <= {{(4*DIGITS){1'b0}}, bus.total};
            ovf_cap <= bus.overflow;
            cnt     <= '0;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= {adj_scr[SW-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: begin
          bcd_r   <= bcd_nxt;
          err_r   <= ovf_cap;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.bcd       = bcd_r;
  assign bus.bcd_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

`ifdef SUM_BCD_SEG_EN
  logic [DIGITS-1:0][6:0] seg_nxt;
  logic [DIGITS-1:0][6:0] seg_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_seg_decode u_dec (
      .digit (bcd_nxt[4*g +: 4]),
      .seg   (seg_nxt[g])
    );
  end

  // Loaded on the same edge as bcd so both stay aligned with bcd_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  seg_r <= '1;
    else if (state == S_DONE) seg_r <= seg_nxt;
  end

  assign bus.seg = seg_r;
`endif

endmodule

// File: tb/tb_sum_result_bcd.sv
// Self-checking bench for sum_result_bcd: directed scenarios plus random traffic,
// compared every cycle against a behavioural model (seg checked under SUM_BCD_SEG_EN).
module tb_sum_result_bcd;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4*DIGITS;

  logic clk = 1'b0;
  logic rst;
  logic chk_en;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rise = 0;

  always #5 clk = ~clk;

  sum_result_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
  sum_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d <= 4'd9) return tbl[d];
    if (d == 4'hF) return 7'h3F;
    return 7'h7F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion takes WIDTH+1 clocks; edges while busy are dropped
  logic          m_rq, m_valid, m_err, m_pend_err;
  int            m_left;
  logic [BW-1:0] m_bcd, m_pend;
  logic [7*DIGITS-1:0] m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rq = 1'b0; m_left = 0; m_valid = 1'b0; m_err = 1'b0; m_bcd = '0; m_seg = '1;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_err   = m_pend_err;
          m_bcd   = m_pend_err ? '1 : m_pend;
          m_valid = 1'b1;
          for (int i = 0; i < DIGITS; i++) m_seg[7*i +: 7] = seg_of(m_bcd[4*i +: 4]);
        end
      end else if (bus.ready && !m_rq) begin
        m_pend     = to_bcd(int'(bus.total));
        m_pend_err = bus.overflow;
        m_left     = WIDTH + 1;
        m_valid    = 1'b0;
      end
      m_rq = bus.ready;
    end
  end

  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd", 32'(bus.bcd), 32'(m_bcd));
      check("bcd_valid", 32'(bus.bcd_valid), 32'(m_valid));
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("err", 32'(bus.err), 32'(m_err));
`ifdef SUM_BCD_SEG_EN
      check("seg", 32'(bus.seg), 32'(m_seg));
`endif
    end
    if (bus.busy && !busy_prev) n_rise++;
    busy_prev = bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.bcd_valid) break;
      lat++;
      if (lat > 40) begin
        check({name, "_timeout"}, 32'(lat), 32'(WIDTH+1));
        break;
      end
    end
  endtask

  // One-cycle ready pulse, then literal checks on latency and result
  task automatic run_conv(input string name, input int t, input bit ovf,
                          input logic [BW-1:0] exp_bcd, input bit exp_err);
    int lat;
    bus.total = WIDTH'(t); bus.overflow = ovf; bus.ready = 1'b1;
    @(posedge clk); #1;
    bus.ready = 1'b0;
    wait_valid(name, lat);
    check({name, "_lat"}, 32'(lat), 32'(WIDTH+1));
    check({name, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0;
    bus.ready = 1'b0; bus.total = '0; bus.overflow = 1'b0;
    rst = 1'b0; chk_en = 1'b0;
    #1 rst = 1'b1; chk_en = 1'b1;
    tick(3);
    check("rst_bcd", 32'(bus.bcd), 32'h0);
    check("rst_valid", 32'(bus.bcd_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    tick(2);

    check("model_pin_137", 32'(to_bcd(137)), 32'h137);
    check("model_pin_seg3", 32'(seg_of(4'd3)), 32'h30);

    run_conv("zero", 0, 1'b0, 12'h000, 1'b0);
    run_conv("max", 255, 1'b0, 12'h255, 1'b0);
    run_conv("v136", 136, 1'b0, 12'h136, 1'b0);
    run_conv("ovf", 36, 1'b1, 12'hFFF, 1'b1);
`ifdef SUM_BCD_SEG_EN
    check("ovf_seg", 32'(bus.seg), 32'({3{7'h3F}}));
`endif

    // ready held high: exactly one conversion
    tick(1);
    r0 = n_rise;
    bus.total = 8'd55; bus.overflow = 1'b0; bus.ready = 1'b1;
    tick(40);
    check("held_once", 32'(n_rise - r0), 32'd1);
    check("held_bcd", 32'(bus.bcd), 32'h055);
    bus.ready = 1'b0;
    tick(2);
    run_conv("again", 201, 1'b0, 12'h201, 1'b0);

    // Second edge mid-SHIFT with a new total is dropped
    tick(1);
    r0 = n_rise;
    bus.total = 8'd17; bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    tick(3);
    bus.total = 8'd200; bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    wait_valid("midpulse", lat);
    check("midpulse_bcd", 32'(bus.bcd), 32'h017);
    tick(20);
    check("midpulse_late_bcd", 32'(bus.bcd), 32'h017);
    check("midpulse_once", 32'(n_rise - r0), 32'd1);

    // Reset in the middle of SHIFT
    bus.total = 8'd88; bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check("midrst_bcd", 32'(bus.bcd), 32'h0);
    check("midrst_valid", 32'(bus.bcd_valid), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    run_conv("after_rst", 99, 1'b0, 12'h099, 1'b0);

    // Random traffic, including edges that arrive while busy
    for (int i = 0; i < 80; i++) begin
      bus.total    = WIDTH'($urandom);
      bus.overflow = ($urandom_range(0, 3) == 0);
      bus.ready    = 1'b1;
      tick($urandom_range(1, 3));
      bus.ready    = 1'b0;
      bus.total    = WIDTH'($urandom);
      tick($urandom_range(0, 14));
    end
    tick(15);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sum_result_bcd.md
Name: sum_result_bcd

Overview:
- Downstream consumer of the summation datapath (control block + operating block).
- Watches `ready` from the control block and captures `total` and `overflow` from the operating block on the rising edge of `ready`.
- Converts the captured binary total to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Presents the digits with a level `bcd_valid` flag for the display or any later consumer.

Parameters:
- WIDTH, 8, bit width of `total`.
- DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- ready  input  1  done flag from the summation control block; may stay high for many cycles.
- total  input  WIDTH  sum from the operating block; valid while `ready` is high.
- overflow  input  1  overflow flag from the operating block; valid with `total`.
- bcd  output  4*DIGITS  digits, units in [3:0], tens in [7:4], hundreds in [11:8].
- bcd_valid  output  1  level flag; `bcd` holds a finished conversion.
- busy  output  1  high while a conversion is in progress.
- err  output  1  the captured result had `overflow` set.

Behaviour:
- Reset (async, rst=1): state=IDLE; bcd=0; bcd_valid=0; busy=0; err=0; ready_q=0; shift count=0.
- Edge detect: ready_q registers `ready` every cycle. A start event is ready=1 and ready_q=0 at a rising clk edge. A held-high `ready` produces exactly one event.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on a start event at edge N:
  - load scratch = {DIGITS*4 zeros, total}; latch ovf_cap=overflow; cnt=0.
  - busy=1; bcd_valid=0; go to SHIFT.
- SHIFT, each edge:
  - first, every scratch digit >= 5 gets +3 (4-bit add, no carry out of the digit);
  - then shift the whole scratch left by 1; cnt++.
  - After the WIDTH-th shift (edge N+WIDTH), go to DONE.
- DONE, at edge N+WIDTH+1:
  - bcd = upper 4*DIGITS scratch bits; err = ovf_cap; bcd_valid=1; busy=0; go to IDLE.
- Latency: start event to bcd_valid=1 is WIDTH+1 clocks (9 for the defaults).
- Hold: bcd, err and bcd_valid stay constant until the next start event. That event clears bcd_valid on the same edge as the load. bcd keeps its old value until the new DONE.
- Overflow: the conversion still runs on the wrapped `total`. If err=1, bcd = all 4'hF (error code), not the converted value.
- Start event while busy (SHIFT or DONE): ignored, not queued. ready_q still tracks `ready`, so the ignored edge never fires later.
- total changing during SHIFT: no effect; only the scratch register is used.
- Reset mid-conversion: immediate return to reset values. Nothing partial ever appears on `bcd`.
- Arithmetic: scratch width = 4*DIGITS + WIDTH; cnt width = clog2(WIDTH+1).

Optional Feature:
- Macro: SUM_BCD_SEG_EN.
- When defined:
  - adds output port `seg` (7*DIGITS bits, active-low, segment order gfedcba), units in [6:0];
  - `seg` is registered, updated on the same edge as `bcd`, so it stays cycle-aligned with bcd_valid;
  - digits 0-9 use standard patterns; 4'hF shows segment g only ("-"); all other codes blank (all 1s);
  - reset value of `seg` is all 1s (blank).
- When undefined: no `seg` port and no decode logic; the rest is identical.

Decomposition:
- Shared package `sum_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - constant BCD_ERR = 4'hF;
  - 7-segment pattern constants.
- One sub-module, `bcd_seg_decode`: purely combinational 4-bit to 7-bit decoder, instantiated DIGITS times, only under SUM_BCD_SEG_EN.

Test Plan:
- total=8'd0, overflow=0, ready 0->1 at cycle 5 -> bcd=12'h000, bcd_valid=1 at cycle 14, busy high for cycles 6-14.
- total=8'd255, overflow=0 -> bcd=12'h255, err=0; total=8'd136 -> bcd=12'h136.
- total=8'd36, overflow=1 -> err=1, bcd=12'hFFF; with SUM_BCD_SEG_EN, seg = three "-" patterns.
- ready held high for 40 cycles with total=8'd55 -> exactly one conversion, bcd=12'h055; ready low then high again -> second conversion, bcd_valid drops for 9 cycles.
- ready pulsed again at cycle 3 of SHIFT with a different total -> ignored; result is from the first capture, no late conversion.
- rst asserted at cycle 4 of SHIFT -> bcd=0, bcd_valid=0, busy=0 at once; next ready edge with total=8'd99 -> bcd=12'h099.
